seven_seg_scan_driver: RTL and testbench



---
 rtl/seven_seg_scan_driver.sv | 151 +++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed common-anode seven-segment driver with blink, leading-zero blanking and frame-aligned updates.
// Outputs registered one cycle after the scan index; new values take effect only at a frame boundary.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic                    lz_blank,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [6:0]              segment,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [6:0]    SEG_BLANK  = 7'h7F;

    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic [BW-1:0]           blink_cnt;
    logic                    blink_phase;
    logic [4*NUM_DIGITS-1:0] pending;
    logic                    pending_valid;
    logic [4*NUM_DIGITS-1:0] display;

    logic                  slot_end;
    logic                  frame_end;
    logic [NUM_DIGITS-1:0] lz_zero;
    logic [3:0]            cur_nib;
    logic                  cur_lz;
    logic                  cur_blink;
    logic                  cur_blank;

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    assign slot_end  = enable && (presc == PRESC_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // lz_zero[i]: nibble i and every nibble above it are zero
    always_comb begin
        logic run;
        run     = 1'b1;
        lz_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run        = run & (display[4*i +: 4] == 4'h0);
            lz_zero[i] = run;
        end
    end

    always_comb begin
        cur_nib   = 4'h0;
        cur_lz    = 1'b0;
        cur_blink = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib   = display[4*i +: 4];
                cur_lz    = lz_zero[i] && (i != 0);
                cur_blink = blink_mask[i];
            end
        end
        cur_blank = (cur_blink & blink_phase) | (lz_blank & cur_lz);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            presc         <= '0;
            idx           <= '0;
            blink_cnt     <= '0;
            blink_phase   <= 1'b0;
            pending       <= '0;
            pending_valid <= 1'b0;
            display       <= '0;
            segment       <= SEG_BLANK;
            digit_sel     <= '1;
            frame_done    <= 1'b0;
        end else begin
            if (enable) begin
                presc <= slot_end ? '0 : presc + 1'b1;
                if (slot_end) begin
                    idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end
            end

            frame_done <= frame_end;

            if (frame_end) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end

            // A load coinciding with the frame boundary bypasses the pending stage
            if (frame_end) begin
                pending_valid <= 1'b0;
                if (load) begin
                    pending <= value;
                    display <= value;
                end else if (pending_valid) begin
                    display <= pending;
                end
            end else if (load) begin
                pending       <= value;
                pending_valid <= 1'b1;
            end

            if (enable) begin
                digit_sel <= ~(NUM_DIGITS'(1) << idx);
                segment   <= cur_blank ? SEG_BLANK : glyph(cur_nib);
            end else begin
                digit_sel <= '1;
                segment   <= SEG_BLANK;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
module tb_seven_seg_scan_driver;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [15:0] value;
    logic        load;
    logic        lz_blank;
    logic [3:0]  blink_mask;
    logic [6:0]  segment;
    logic [3:0]  digit_sel;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    seven_seg_scan_driver #(
        .NUM_DIGITS  (4),
        .SCAN_DIV    (4),
        .BLINK_FRAMES(2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .value     (value),
        .load      (load),
        .lz_blank  (lz_blank),
        .blink_mask(blink_mask),
        .segment   (segment),
        .digit_sel (digit_sel),
        .frame_done(frame_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] e_sel, input logic [6:0] e_seg, input logic e_fd);
        checks++;
        assert (digit_sel === e_sel) else begin
            errors++;
            $error("FAIL %s digit_sel: observed %b expected %b", tag, digit_sel, e_sel);
        end
        checks++;
        assert (segment === e_seg) else begin
            errors++;
            $error("FAIL %s segment: observed %h expected %h", tag, segment, e_seg);
        end
        checks++;
        assert (frame_done === e_fd) else begin
            errors++;
            $error("FAIL %s frame_done: observed %b expected %b", tag, frame_done, e_fd);
        end
    endtask

    // One 16-cycle frame aligned to prescaler 0 / index 0; optional load at cycle ld_at.
    task automatic check_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3,
                               input int ld_at, input logic [15:0] ld_v);
        logic [6:0] segs [4];
        logic [3:0] sel;
        segs[0] = s0;
        segs[1] = s1;
        segs[2] = s2;
        segs[3] = s3;
        for (int c = 0; c < 16; c++) begin
            if (c == ld_at) begin
                value = ld_v;
                load  = 1'b1;
            end
            tick();
            load = 1'b0;
            sel = 4'b1111;
            sel[c/4] = 1'b0;
            chk(tag, sel, segs[c/4], (c == 15));
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        load   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic load_idle(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        tick();
        load = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        value      = 16'h0000;
        load       = 1'b0;
        lz_blank   = 1'b0;
        blink_mask = 4'b0000;

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset", 4'b1111, 7'h7F, 1'b0);
        end
        reset = 1'b0;

        // Basic scan, mid-frame load, load on the frame-end cycle
        load_idle(16'h12AF);
        chk("idle_after_load", 4'b1111, 7'h7F, 1'b0);
        enable = 1'b1;
        check_frame("scan_f1", 7'h40, 7'h40, 7'h40, 7'h40, -1, 16'h0);
        check_frame("scan_12AF", 7'h0E, 7'h08, 7'h24, 7'h79, 5, 16'h1111);
        check_frame("scan_1111", 7'h79, 7'h79, 7'h79, 7'h79, 15, 16'h2B3C);
        check_frame("scan_2B3C", 7'h46, 7'h30, 7'h03, 7'h24, -1, 16'h0);
        check_frame("scan_2B3C_hold", 7'h46, 7'h30, 7'h03, 7'h24, -1, 16'h0);

        // Leading-zero suppression
        do_reset();
        lz_blank = 1'b1;
        load_idle(16'h0005);
        enable = 1'b1;
        check_frame("lz_0000", 7'h40, 7'h7F, 7'h7F, 7'h7F, -1, 16'h0);
        check_frame("lz_0005", 7'h12, 7'h7F, 7'h7F, 7'h7F, 8, 16'h0500);
        check_frame("lz_0500", 7'h40, 7'h40, 7'h12, 7'h7F, -1, 16'h0);
        lz_blank = 1'b0;

        // Blink on digit 2: two frames lit, two frames dark
        do_reset();
        blink_mask = 4'b0100;
        load_idle(16'h12AF);
        enable = 1'b1;
        check_frame("blink_f1", 7'h40, 7'h40, 7'h40, 7'h40, -1, 16'h0);
        check_frame("blink_f2", 7'h0E, 7'h08, 7'h24, 7'h79, -1, 16'h0);
        check_frame("blink_f3", 7'h0E, 7'h08, 7'h7F, 7'h79, -1, 16'h0);
        check_frame("blink_f4", 7'h0E, 7'h08, 7'h7F, 7'h79, -1, 16'h0);
        check_frame("blink_f5", 7'h0E, 7'h08, 7'h24, 7'h79, -1, 16'h0);

        // Pause mid-slot in digit 1, with a load while dark
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i < 4) chk("pre_pause_d0", 4'b1110, 7'h0E, 1'b0);
            else       chk("pre_pause_d1", 4'b1101, 7'h08, 1'b0);
        end
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                value = 16'h3210;
                load  = 1'b1;
            end
            tick();
            load = 1'b0;
            chk("paused_dark", 4'b1111, 7'h7F, 1'b0);
        end
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i < 2)      chk("resume_d1", 4'b1101, 7'h08, 1'b0);
            else if (i < 6) chk("resume_d2", 4'b1011, 7'h24, 1'b0);
            else            chk("resume_d3", 4'b0111, 7'h79, (i == 9));
        end
        check_frame("after_pause", 7'h40, 7'h79, 7'h7F, 7'h30, -1, 16'h0);

        // Reset mid-frame wins over a same-cycle load
        reset = 1'b1;
        value = 16'hFFFF;
        load  = 1'b1;
        tick();
        chk("reset_mid", 4'b1111, 7'h7F, 1'b0);
        reset      = 1'b0;
        load       = 1'b0;
        enable     = 1'b0;
        blink_mask = 4'b0000;
        tick();
        chk("post_reset_idle", 4'b1111, 7'h7F, 1'b0);
        enable = 1'b1;
        check_frame("post_reset_f1", 7'h40, 7'h40, 7'h40, 7'h40, -1, 16'h0);
        check_frame("post_reset_f2", 7'h40, 7'h40, 7'h40, 7'h40, -1, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
